// File: rtl/inst_fetch_unit_pkg.sv
// rtl/inst_fetch_unit_pkg.sv - shared types, defaults and helpers for the instruction fetch unit
package inst_fetch_unit_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'hBFC0_0000;
  localparam int          DEFAULT_BUF_DEPTH = 2;
  localparam int          INST_W            = 32;
  localparam int          PC_W              = 32;

  // 65-bit buffer entry {adel, pc, inst}
  typedef struct packed {
    logic              adel;
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic word_aligned(input logic [PC_W-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_buf.sv
// rtl/inst_fetch_unit_buf.sv - DEPTH-entry instruction buffer FIFO with flush
module inst_fetch_unit_buf
  import inst_fetch_unit_pkg::*;
#(
  parameter int DEPTH = DEFAULT_BUF_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  fetch_entry_t               push_entry,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output fetch_entry_t               head
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t    mem_q [DEPTH];
  fetch_entry_t    mem_d [DEPTH];
  logic [PW-1:0]   wr_q, wr_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   count_q, count_d;

  // Explicit wrap so non-power-of-two depths stay correct
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = push_entry;
        wr_d        = next_ptr(wr_q);
      end
      if (pop) begin
        rd_d = next_ptr(rd_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign full  = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
  assign head  = mem_q[rd_q];

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - PC owner, instruction SRAM request credit logic and decode handshake
// Defining IFETCH_PERF_EN adds perf_fetch_cnt / perf_bubble_cnt counter outputs.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = DEFAULT_BUF_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        id_adel
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int OW = CW + 1;
  localparam logic [OW-1:0] DEPTH_W = OW'(BUF_DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic          inflight_q, inflight_d;
  logic          halted_q, halted_d;

  logic          buf_full, buf_empty;
  logic [CW-1:0] buf_count;
  fetch_entry_t  buf_head;
  fetch_entry_t  push_entry;
  logic          push, pop, issue, drop;
  logic          resp_push, adel_push, misaligned;
  logic [OW-1:0] occupancy;

  always_comb begin
    pop        = !buf_empty && id_ready;
    // A head leaving this cycle frees its slot, which keeps depth 2 at full rate
    occupancy  = OW'(buf_count) + OW'(inflight_q) - OW'(pop);
    misaligned = !word_aligned(pc_q);
    drop       = redirect_valid;
    issue      = !reset && !halted_q && !redirect_valid && !misaligned && (occupancy < DEPTH_W);
    resp_push  = inflight_q && !drop;
    adel_push  = !halted_q && !redirect_valid && misaligned && !inflight_q && (occupancy < DEPTH_W);
    push       = (resp_push || adel_push) && (!buf_full || pop);

    push_entry = '0;
    if (resp_push) begin
      push_entry.pc   = resp_pc_q;
      push_entry.inst = inst_sram_rdata;
    end else begin
      push_entry.adel = 1'b1;
      push_entry.pc   = pc_q;
    end

    pc_d       = pc_q;
    halted_d   = halted_q;
    inflight_d = issue;
    resp_pc_d  = issue ? pc_q : resp_pc_q;
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      halted_d = 1'b0;
    end else begin
      if (issue) pc_d = pc_q + 32'd4;
      if (adel_push) halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      resp_pc_q  <= '0;
      inflight_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      halted_q   <= halted_d;
    end
  end

  inst_fetch_unit_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .full       (buf_full),
    .empty      (buf_empty),
    .count      (buf_count),
    .head       (buf_head)
  );

  assign inst_sram_en   = issue;
  assign inst_sram_addr = pc_q;
  assign id_valid       = !buf_empty;
  assign id_inst        = buf_empty ? 32'd0 : buf_head.inst;
  assign id_pc          = buf_empty ? 32'd0 : buf_head.pc;
  assign id_adel        = !buf_empty && buf_head.adel;

`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q + (issue ? 32'd1 : 32'd0);
    bubble_cnt_d = bubble_cnt_q + ((id_ready && buf_empty) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - directed vector bench for inst_fetch_unit
module tb_inst_fetch_unit;

  localparam logic [31:0] B = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_adel;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_rdata (inst_sram_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_inst         (id_inst),
    .id_pc           (id_pc),
    .id_adel         (id_adel)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  function automatic logic [31:0] inst_fn(input logic [31:0] a);
    return ~a ^ 32'h5A5A_0000;
  endfunction

  // Synchronous SRAM: word for the requested address appears the cycle after en
  always @(posedge clk) begin
    inst_sram_rdata <= inst_sram_en ? inst_fn(inst_sram_addr) : 32'h0BAD_0BAD;
  end

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        en;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic        adel;
  } row_t;

  row_t rows[$];

  function automatic row_t mk(input logic rst, input logic redir, input logic [31:0] rpc,
                              input logic rdy, input logic en, input logic [31:0] addr,
                              input logic vld, input logic [31:0] pc, input logic adel);
    row_t r;
    r.rst = rst; r.redir = redir; r.rpc = rpc; r.rdy = rdy;
    r.en = en; r.addr = addr; r.vld = vld; r.pc = pc; r.adel = adel;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Startup and steady streaming
    rows.push_back(mk(1, 0, 0, 0, 0, 0,        0, 0,        0));
    rows.push_back(mk(0, 0, 0, 1, 1, B,        0, 0,        0));
    rows.push_back(mk(0, 0, 0, 1, 1, B+4,      0, 0,        0));
    rows.push_back(mk(0, 0, 0, 1, 1, B+8,      1, B,        0));
    rows.push_back(mk(0, 0, 0, 1, 1, B+12,     1, B+4,      0));
    rows.push_back(mk(0, 0, 0, 1, 1, B+16,     1, B+8,      0));
    // Decode stalls five cycles: two entries held, no requests
    for (int i = 0; i < 5; i++) rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, B+12, 0));
    rows.push_back(mk(0, 0, 0, 1, 1, B+20,     1, B+12,     0));
    rows.push_back(mk(0, 0, 0, 1, 1, B+24,     1, B+16,     0));
    rows.push_back(mk(0, 0, 0, 1, 1, B+28,     1, B+20,     0));
    // Redirect coinciding with the B+28 response
    rows.push_back(mk(0, 1, 32'h8000_0100, 1, 0, 0, 1, B+24, 0));
    rows.push_back(mk(0, 0, 0, 1, 1, 32'h8000_0100, 0, 0, 0));
    rows.push_back(mk(0, 0, 0, 1, 1, 32'h8000_0104, 0, 0, 0));
    rows.push_back(mk(0, 0, 0, 1, 1, 32'h8000_0108, 1, 32'h8000_0100, 0));
    // Misaligned redirect: single adel entry, then halted
    rows.push_back(mk(0, 1, 32'h8000_0102, 1, 0, 0, 1, 32'h8000_0104, 0));
    rows.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h8000_0102, 1));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h8000_0102, 1));
    rows.push_back(mk(0, 0, 0, 1, 0, 0, 1, 32'h8000_0102, 1));
    rows.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 32'h8000_0200, 1, 0, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 0, 1, 1, 32'h8000_0200, 0, 0, 0));
    rows.push_back(mk(0, 0, 0, 1, 1, 32'h8000_0204, 0, 0, 0));
    rows.push_back(mk(0, 0, 0, 1, 1, 32'h8000_0208, 1, 32'h8000_0200, 0));
    rows.push_back(mk(0, 0, 0, 1, 1, 32'h8000_020C, 1, 32'h8000_0204, 0));
    // Fill the buffer, then reset mid-stream
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h8000_0208, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h8000_0208, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 0, 1, 1, B,   0, 0, 0));
    rows.push_back(mk(0, 0, 0, 1, 1, B+4, 0, 0, 0));
    rows.push_back(mk(0, 0, 0, 1, 1, B+8, 1, B, 0));

    #1;
    for (int i = 0; i < rows.size(); i++) begin
      reset          = rows[i].rst;
      redirect_valid = rows[i].redir;
      redirect_pc    = rows[i].rpc;
      id_ready       = rows[i].rdy;
      @(negedge clk);
      chk($sformatf("row%0d en", i), 32'(inst_sram_en), 32'(rows[i].en));
      if (rows[i].en) chk($sformatf("row%0d addr", i), inst_sram_addr, rows[i].addr);
      chk($sformatf("row%0d id_valid", i), 32'(id_valid), 32'(rows[i].vld));
      if (rows[i].vld || rows[i].rst) begin
        chk($sformatf("row%0d id_pc", i), id_pc, rows[i].pc);
        chk($sformatf("row%0d id_adel", i), 32'(id_adel), 32'(rows[i].adel));
        chk($sformatf("row%0d id_inst", i), id_inst,
            (rows[i].adel || rows[i].rst) ? 32'd0 : inst_fn(rows[i].pc));
      end
      step();
    end

    // Redirect with decode stalled: bounded wait for the first word, then hold and drain
    begin
      bit seen;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_1000;
      id_ready       = 1'b0;
      step();
      redirect_valid = 1'b0;
      seen = 1'b0;
      for (int t = 0; t < 8 && !seen; t++) begin
        @(negedge clk);
        if (id_valid) seen = 1'b1;
        else step();
      end
      chk("wait first word", 32'(seen), 32'd1);
      chk("first word pc", id_pc, 32'h0000_1000);
      for (int t = 0; t < 3; t++) step();
      @(negedge clk);
      chk("stall no request", 32'(inst_sram_en), 32'd0);
      chk("stall head pc", id_pc, 32'h0000_1000);
      step();
      id_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk($sformatf("drain%0d valid", k), 32'(id_valid), 32'd1);
        chk($sformatf("drain%0d pc", k), id_pc, 32'h0000_1000 + 32'(4 * k));
        chk($sformatf("drain%0d inst", k), id_inst, inst_fn(32'h0000_1000 + 32'(4 * k)));
        step();
      end
    end

`ifdef IFETCH_PERF_EN
    // 2 requests with ready low, 8 more streaming, misaligned stop, 3 starved cycles
    reset    = 1'b1;
    id_ready = 1'b0;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("perf fetch reset", perf_fetch_cnt, 32'd0);
    chk("perf bubble reset", perf_bubble_cnt, 32'd0);
    step();
    step();
    id_ready = 1'b1;
    for (int t = 0; t < 8; t++) step();
    id_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0002;
    step();
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    for (int t = 0; t < 4; t++) step();
    id_ready = 1'b0;
    @(negedge clk);
    chk("perf fetch count", perf_fetch_cnt, 32'd10);
    chk("perf bubble count", perf_bubble_cnt, 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
